alu_sequencer: RTL and testbench

Control-side counterpart of the Lab 10 accumulator/ALU datapath (buffers E1/E3, accumulator E2, ALU select S, flags C/Z).
- Fetches 8-bit instructions from an external program ROM.
- Drives the datapath's enables, operation select and 4-bit operand.
- Reads C/Z back for conditional jumps.
- Replaces hand-written stimulus sequences with a stored program.

---
 rtl/alu_seq_pkg.sv | 55 +++++
 rtl/alu_seq_decode.sv | 37 +++
 rtl/alu_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU sequencer.
//   - instruction field positions (opcode / operand nibbles)
//   - opcode constants for the non-ALU instructions (0x0-0x7 are ALU ops)
//   - jump condition select encoding
//   - FSM state encoding; the PAUSE state exists only when SINGLE_STEP_EN
//     is defined
package alu_seq_pkg;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;
    localparam int OPN_HI = 3;
    localparam int OPN_LO = 0;

    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_NOP  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JNZ  = 4'hD;
    localparam logic [3:0] OP_WAIT = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'd0,
        COND_C      = 2'd1,
        COND_Z      = 2'd2,
        COND_NZ     = 2'd3
    } cond_e;

`ifdef SINGLE_STEP_EN
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EXEC    = 4'd3,
        ST_FETCH2  = 4'd4,
        ST_LOADPC  = 4'd5,
        ST_WAITING = 4'd6,
        ST_HALTED  = 4'd7,
        ST_PAUSE   = 4'd8
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_FETCH2  = 3'd4,
        ST_LOADPC  = 3'd5,
        ST_WAITING = 3'd6,
        ST_HALTED  = 3'd7
    } state_e;
`endif

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational opcode classifier.
//   opc      in  4  opcode nibble of the instruction being decoded
//   is_alu   out 1  opcode 0x0-0x7
//   is_out   out 1  OUT
//   is_jump  out 1  JMP/JC/JZ/JNZ (two-byte instructions)
//   is_wait  out 1  WAIT n
//   is_halt  out 1  HALT
//   cond_sel out 2  jump condition (always / C / Z / !Z)
// NOP decodes to all-zero flags and falls through to EXEC in the FSM.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] opc,
    output logic       is_alu,
    output logic       is_out,
    output logic       is_jump,
    output logic       is_wait,
    output logic       is_halt,
    output cond_e      cond_sel
);

    always_comb begin
        is_alu   = ~opc[3];
        is_out   = (opc == OP_OUT);
        is_jump  = (opc == OP_JMP) || (opc == OP_JC) ||
                   (opc == OP_JZ)  || (opc == OP_JNZ);
        is_wait  = (opc == OP_WAIT);
        is_halt  = (opc == OP_HALT);
        case (opc)
            OP_JC:   cond_sel = COND_C;
            OP_JZ:   cond_sel = COND_Z;
            OP_JNZ:  cond_sel = COND_NZ;
            default: cond_sel = COND_ALWAYS;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: stored-program controller for the accumulator/ALU datapath.
// Fetches 8-bit instructions from an external synchronous ROM and drives the
// datapath strobes, ALU select and operand; C/Z feed conditional jumps.
//   CLK     in   1     clock, rising edge
//   R       in   1     asynchronous active-low reset
//   START   in   1     start pulse, honoured in IDLE/HALTED only
//   STEP    in   1     single-step pulse (only with SINGLE_STEP_EN)
//   PC      out  PC_W  ROM address
//   INSTR   in   8     ROM data, one cycle after PC
//   C_IN    in   1     datapath carry flag
//   Z_IN    in   1     datapath zero flag
//   E1/E2   out  1     input buffer / accumulator enables (ALU EXEC)
//   E3      out  1     output buffer enable (OUT EXEC)
//   S       out  3     ALU select, holds last ALU value
//   OPND    out  4     operand, holds last ALU value
//   BUSY    out  1     not IDLE/HALTED
//   HALTED  out  1     in HALTED
// Optional: define SINGLE_STEP_EN to add STEP and a PAUSE state after every
// EXEC, LOADPC and WAITING completion.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PC_W   = 7,
    parameter int WAIT_W = 4
) (
    input  logic            CLK,
    input  logic            R,
    input  logic            START,
`ifdef SINGLE_STEP_EN
    input  logic            STEP,
`endif
    output logic [PC_W-1:0] PC,
    input  logic [7:0]      INSTR,
    input  logic            C_IN,
    input  logic            Z_IN,
    output logic            E1,
    output logic            E2,
    output logic            E3,
    output logic [2:0]      S,
    output logic [3:0]      OPND,
    output logic            BUSY,
    output logic            HALTED
);

    localparam logic [PC_W-1:0]   PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};

    // Where an instruction goes once it has finished.
`ifdef SINGLE_STEP_EN
    localparam state_e ST_DONE = ST_PAUSE;
`else
    localparam state_e ST_DONE = ST_FETCH;
`endif

    state_e            state;
    logic [PC_W-1:0]   pc;
    logic [WAIT_W-1:0] wcnt;
    logic              taken;

    logic              is_alu, is_out, is_jump, is_wait, is_halt;
    cond_e             cond_sel;
    logic              cond_met;
    logic [3:0]        opnd_in;

    // The decoder only matters in DECODE, when INSTR holds the byte that
    // was fetched. Its fields are consumed there directly into the output,
    // counter and taken registers, so nothing downstream re-reads the byte.
    alu_seq_decode u_dec (
        .opc      (INSTR[OPC_HI:OPC_LO]),
        .is_alu   (is_alu),
        .is_out   (is_out),
        .is_jump  (is_jump),
        .is_wait  (is_wait),
        .is_halt  (is_halt),
        .cond_sel (cond_sel)
    );

    assign opnd_in = INSTR[OPN_HI:OPN_LO];

    always_comb begin
        case (cond_sel)
            COND_C:  cond_met = C_IN;
            COND_Z:  cond_met = Z_IN;
            COND_NZ: cond_met = ~Z_IN;
            default: cond_met = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state <= ST_IDLE;
            pc    <= '0;
            wcnt  <= '0;
            taken <= 1'b0;
            E1    <= 1'b0;
            E2    <= 1'b0;
            E3    <= 1'b0;
            S     <= '0;
            OPND  <= '0;
        end else begin
            // Strobes are one-shot: only the DECODE->EXEC transition sets them.
            E1 <= 1'b0;
            E2 <= 1'b0;
            E3 <= 1'b0;
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (START) begin
                        state <= ST_FETCH;
                        pc    <= '0;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    pc    <= pc + PC_ONE;
                    taken <= cond_met;
                    if (is_jump) begin
                        state <= ST_FETCH2;
                    end else if (is_halt) begin
                        state <= ST_HALTED;
                    end else if (is_wait && (opnd_in != 4'd0)) begin
                        state <= ST_WAITING;
                        wcnt  <= WAIT_W'(opnd_in - 4'd1);
                    end else begin
                        // ALU, OUT, NOP and WAIT 0 all spend one EXEC cycle
                        state <= ST_EXEC;
                        if (is_alu) begin
                            E1   <= 1'b1;
                            E2   <= 1'b1;
                            S    <= INSTR[OPC_LO+2:OPC_LO];
                            OPND <= opnd_in;
                        end
                        if (is_out) E3 <= 1'b1;
                    end
                end
                ST_EXEC:   state <= ST_DONE;
                ST_FETCH2: state <= ST_LOADPC;
                ST_LOADPC: begin
                    // INSTR now holds the target byte fetched in FETCH2
                    pc    <= taken ? INSTR[PC_W-1:0] : pc + PC_ONE;
                    state <= ST_DONE;
                end
                ST_WAITING: begin
                    if (wcnt == '0) state <= ST_DONE;
                    else            wcnt  <= wcnt - WAIT_ONE;
                end
`ifdef SINGLE_STEP_EN
                ST_PAUSE: if (STEP) state <= ST_FETCH;
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign PC     = pc;
    assign BUSY   = (state != ST_IDLE) && (state != ST_HALTED);
    assign HALTED = (state == ST_HALTED);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       r, start, c_in, z_in;
    logic [7:0] instr;
    logic [6:0] pc;
    logic       e1, e2, e3, busy, halted;
    logic [2:0] s;
    logic [3:0] opnd;
    logic [7:0] rom [128];

    logic       start_w, c_w, z_w;
    logic [7:0] instr_w;
    logic [2:0] pc_w;
    logic       e1_w, e2_w, e3_w, busy_w, halted_w;
    logic [2:0] s_w;
    logic [3:0] opnd_w;
    logic [7:0] rom_w [8];

`ifdef SINGLE_STEP_EN
    logic step = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // synchronous ROMs: data appears the cycle after the address
    always @(posedge clk) instr   <= rom[pc];
    always @(posedge clk) instr_w <= rom_w[pc_w];

    alu_sequencer #(.PC_W(7), .WAIT_W(4)) u_dut (
        .CLK(clk), .R(r), .START(start),
`ifdef SINGLE_STEP_EN
        .STEP(step),
`endif
        .PC(pc), .INSTR(instr), .C_IN(c_in), .Z_IN(z_in),
        .E1(e1), .E2(e2), .E3(e3), .S(s), .OPND(opnd),
        .BUSY(busy), .HALTED(halted)
    );

    alu_sequencer #(.PC_W(3), .WAIT_W(4)) u_wrap (
        .CLK(clk), .R(r), .START(start_w),
`ifdef SINGLE_STEP_EN
        .STEP(step),
`endif
        .PC(pc_w), .INSTR(instr_w), .C_IN(c_w), .Z_IN(z_w),
        .E1(e1_w), .E2(e2_w), .E3(e3_w), .S(s_w), .OPND(opnd_w),
        .BUSY(busy_w), .HALTED(halted_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 128; i++) rom[i] = v;
    endtask

    // after this returns the DUT is in its first FETCH cycle (cycle 1)
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b0; start = 1'b0; c_in = 1'b0; z_in = 1'b0;
        start_w = 1'b0; c_w = 1'b0; z_w = 1'b0;
        fill_rom(8'hF0);
        for (int i = 0; i < 8; i++) rom_w[i] = 8'hF0;
        ticks(2);
        checks++;
        if ({e1, e2, e3, s, opnd, busy, halted} !== 13'd0 || pc !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got e=%b%b%b s=%h opnd=%h busy=%b halted=%b pc=%h, expected all zero",
                     e1, e2, e3, s, opnd, busy, halted, pc);
        end
        r = 1'b1;
        ticks(2);
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hold: got busy=%b halted=%b, expected 0 0", busy, halted);
        end
    endtask

    task automatic test_reset_mid_exec();
        fill_rom(8'hF0);
        rom[0] = 8'h35;
        pulse_start();
        checks++;
        if (pc !== 7'd0 || busy !== 1'b1 || e1 !== 1'b0) begin
            errors++;
            $display("FAIL startup_fetch: got pc=%h busy=%b e1=%b, expected 00 1 0", pc, busy, e1);
        end
        tick();
        checks++;
        if ({e1, e2, e3} !== 3'b000) begin
            errors++;
            $display("FAIL startup_decode_quiet: got e=%b, expected 000", {e1, e2, e3});
        end
        tick();
        checks++;
        if ({e1, e2, e3, s, opnd} !== {3'b110, 3'd3, 4'd5}) begin
            errors++;
            $display("FAIL startup_exec: got e=%b s=%h opnd=%h, expected 110 3 5", {e1, e2, e3}, s, opnd);
        end
        #1 r = 1'b0;
        #1;
        checks++;
        if ({e1, e2, e3, s, opnd, busy, halted} !== 13'd0 || pc !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_exec: got e=%b s=%h opnd=%h busy=%b pc=%h, expected all zero",
                     {e1, e2, e3}, s, opnd, busy, pc);
        end
        tick();
        r = 1'b1;
        ticks(2);
        checks++;
        if (busy !== 1'b0 || {e1, e2, e3} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b e=%b, expected 0 000", busy, {e1, e2, e3});
        end
    endtask

    task automatic test_alu_program();
        fill_rom(8'hF0);
        rom[0] = 8'h25; rom[1] = 8'h80; rom[2] = 8'h7A; rom[3] = 8'h90; rom[4] = 8'hF0;
        pulse_start();
        ticks(2); // cycle 3
        checks++;
        if ({e1, e2, e3, s, opnd} !== {3'b110, 3'd2, 4'd5}) begin
            errors++;
            $display("FAIL alu_exec: got e=%b s=%h opnd=%h, expected 110 2 5", {e1, e2, e3}, s, opnd);
        end
        tick(); // cycle 4
        checks++;
        if (pc !== 7'd1 || {e1, e2, e3} !== 3'b000 || s !== 3'd2 || opnd !== 4'd5) begin
            errors++;
            $display("FAIL alu_after_exec: got pc=%h e=%b s=%h opnd=%h, expected 01 000 2 5", pc, {e1, e2, e3}, s, opnd);
        end
        ticks(2); // cycle 6
        checks++;
        if ({e1, e2, e3, s, opnd} !== {3'b001, 3'd2, 4'd5}) begin
            errors++;
            $display("FAIL out_exec: got e=%b s=%h opnd=%h, expected 001 2 5", {e1, e2, e3}, s, opnd);
        end
        ticks(3); // cycle 9
        checks++;
        if ({e1, e2, e3, s, opnd} !== {3'b110, 3'd7, 4'hA}) begin
            errors++;
            $display("FAIL alu_back_to_back: got e=%b s=%h opnd=%h, expected 110 7 a", {e1, e2, e3}, s, opnd);
        end
        ticks(3); // cycle 12, NOP in EXEC
        checks++;
        if ({e1, e2, e3, s, opnd, busy} !== {3'b000, 3'd7, 4'hA, 1'b1}) begin
            errors++;
            $display("FAIL nop_exec_hold: got e=%b s=%h opnd=%h busy=%b, expected 000 7 a 1", {e1, e2, e3}, s, opnd, busy);
        end
        ticks(3); // cycle 15
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 7'd5) begin
            errors++;
            $display("FAIL halt_at_4: got halted=%b busy=%b pc=%h, expected 1 0 05", halted, busy, pc);
        end
        ticks(3);
        checks++;
        if (halted !== 1'b1 || pc !== 7'd5 || s !== 3'd7) begin
            errors++;
            $display("FAIL halt_frozen: got halted=%b pc=%h s=%h, expected 1 05 7", halted, pc, s);
        end
    endtask

    task automatic test_halt_restart();
        fill_rom(8'hF0);
        for (int i = 0; i < 4; i++) rom[i] = 8'h90;
        pulse_start(); // cycle 1, restart from HALTED
        checks++;
        if (pc !== 7'd0 || busy !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_halt: got pc=%h busy=%b halted=%b, expected 00 1 0", pc, busy, halted);
        end
        ticks(3);      // cycle 4, busy
        pulse_start(); // cycle 5, must be ignored
        ticks(8);      // cycle 13: FETCH of address 4
        checks++;
        if (pc !== 7'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_busy: got pc=%h busy=%b, expected 04 1", pc, busy);
        end
        tick();
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_timing_early: got halted=%b, expected 0", halted);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || pc !== 7'd5) begin
            errors++;
            $display("FAIL halt_restart_end: got halted=%b pc=%h, expected 1 05", halted, pc);
        end
    endtask

    task automatic test_cond_jump();
        logic [7:0] op  [7];
        logic [7:0] tg  [7];
        logic       cc  [7];
        logic       zz  [7];
        logic [6:0] exp_pc [7];
        logic [6:0] exp_end;
        op[0] = 8'hC0; tg[0] = 8'h10; cc[0] = 1'b0; zz[0] = 1'b1; exp_pc[0] = 7'h10;
        op[1] = 8'hC0; tg[1] = 8'h10; cc[1] = 1'b0; zz[1] = 1'b0; exp_pc[1] = 7'h02;
        op[2] = 8'hB0; tg[2] = 8'h20; cc[2] = 1'b1; zz[2] = 1'b0; exp_pc[2] = 7'h20;
        op[3] = 8'hB0; tg[3] = 8'h20; cc[3] = 1'b0; zz[3] = 1'b1; exp_pc[3] = 7'h02;
        op[4] = 8'hD0; tg[4] = 8'h30; cc[4] = 1'b1; zz[4] = 1'b0; exp_pc[4] = 7'h30;
        op[5] = 8'hD0; tg[5] = 8'h30; cc[5] = 1'b0; zz[5] = 1'b1; exp_pc[5] = 7'h02;
        op[6] = 8'hA5; tg[6] = 8'hC4; cc[6] = 1'b0; zz[6] = 1'b0; exp_pc[6] = 7'h44;
        for (int k = 0; k < 7; k++) begin
            fill_rom(8'hF0);
            rom[0] = op[k];
            rom[1] = tg[k];
            c_in = cc[k];
            z_in = zz[k];
            pulse_start(); // cycle 1
            tick();        // cycle 2, flags sampled at the end of this cycle
            tick();        // cycle 3, FETCH2
            c_in = ~cc[k]; // later flag changes must not matter
            z_in = ~zz[k];
            checks++;
            if (pc !== 7'd1 || {e1, e2, e3} !== 3'b000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL jump_fetch2[%0d]: got pc=%h e=%b busy=%b, expected 01 000 1", k, pc, {e1, e2, e3}, busy);
            end
            ticks(2); // cycle 5
            checks++;
            if (pc !== exp_pc[k] || busy !== 1'b1) begin
                errors++;
                $display("FAIL jump_target[%0d]: got pc=%h busy=%b, expected %h 1", k, pc, busy, exp_pc[k]);
            end
            ticks(2); // cycle 7, HALT at target
            exp_end = exp_pc[k] + 7'd1;
            checks++;
            if (halted !== 1'b1 || pc !== exp_end) begin
                errors++;
                $display("FAIL jump_halt[%0d]: got halted=%b pc=%h, expected 1 %h", k, halted, pc, exp_end);
            end
        end
        c_in = 1'b0;
        z_in = 1'b0;
    endtask

    task automatic test_wait();
        logic [3:0] nv [3];
        int         len;
        nv[0] = 4'd3; nv[1] = 4'd0; nv[2] = 4'd1;
        for (int k = 0; k < 3; k++) begin
            fill_rom(8'hF0);
            rom[0] = {4'hE, nv[k]};
            len = (nv[k] == 4'd0) ? 3 : int'(nv[k]) + 2;
            pulse_start();
            for (int c = 1; c <= len; c++) begin
                checks++;
                if (busy !== 1'b1 || {e1, e2, e3} !== 3'b000) begin
                    errors++;
                    $display("FAIL wait_stall[%0d] cycle %0d: got busy=%b e=%b, expected 1 000", k, c, busy, {e1, e2, e3});
                end
                tick();
            end
            checks++;
            if (pc !== 7'd1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL wait_next_fetch[%0d]: got pc=%h busy=%b, expected 01 1", k, pc, busy);
            end
            ticks(2);
            checks++;
            if (halted !== 1'b1 || pc !== 7'd2) begin
                errors++;
                $display("FAIL wait_halt[%0d]: got halted=%b pc=%h, expected 1 02", k, halted, pc);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) rom_w[i] = 8'h90;
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        ticks(21); // cycle 22: FETCH of address 7
        checks++;
        if (pc_w !== 3'd7) begin
            errors++;
            $display("FAIL wrap_pc7: got pc=%h, expected 7", pc_w);
        end
        ticks(3); // cycle 25
        checks++;
        if (pc_w !== 3'd0 || busy_w !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pc0: got pc=%h busy=%b, expected 0 1", pc_w, busy_w);
        end
        r = 1'b0;
        tick();
        r = 1'b1;
        tick();
        // JMP at 0 -> 7; JMP at 7 takes its target byte from address 0
        for (int i = 0; i < 8; i++) rom_w[i] = 8'hF0;
        rom_w[0] = 8'hA6;
        rom_w[1] = 8'h07;
        rom_w[7] = 8'hA0;
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        ticks(4); // cycle 5
        checks++;
        if (pc_w !== 3'd7) begin
            errors++;
            $display("FAIL wrap_jump_to7: got pc=%h, expected 7", pc_w);
        end
        ticks(2); // cycle 7, FETCH2 of the wrapped address
        checks++;
        if (pc_w !== 3'd0) begin
            errors++;
            $display("FAIL wrap_fetch2: got pc=%h, expected 0", pc_w);
        end
        ticks(2); // cycle 9
        checks++;
        if (pc_w !== 3'd6) begin
            errors++;
            $display("FAIL wrap_target: got pc=%h, expected 6", pc_w);
        end
        ticks(2); // cycle 11
        checks++;
        if (halted_w !== 1'b1 || pc_w !== 3'd7) begin
            errors++;
            $display("FAIL wrap_halt: got halted=%b pc=%h, expected 1 7", halted_w, pc_w);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_alu_program();
        test_halt_restart();
        test_cond_jump();
        test_wait();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
